mem_port_arbiter: RTL and testbench

- Shares the single data-memory port (DPI-backed pmem access, `MemOp` size encoding) between the instruction-fetch unit (IFU) and the load/store unit (LSU) of the multi-cycle NPC.
- Latches one winning request, drives it to memory with a valid/ready handshake, waits for the response and routes it back to the owner.
- Only one transaction is outstanding at any time.
- LSU has fixed priority; a starvation counter guarantees IFU forward progress.

---
 rtl/npc_mem_pkg.sv | 43 ++++
 rtl/arb_prio_starve.sv | 55 +++++
 rtl/mem_port_arbiter.sv | 189 ++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/npc_mem_pkg.sv
// -----------------------------------------------------------------------------
// npc_mem_pkg
// Shared definitions for the NPC data-memory port arbiter:
//   - MemOp size codes passed through to the memory untouched
//   - arbiter FSM state encoding
//   - transaction owner encoding
//   - starvation counter width (STARVE_MAX may range 1..15)
// -----------------------------------------------------------------------------
package npc_mem_pkg;

  // MemOp size codes; the memory side does lane selection and extension.
  localparam logic [2:0] MEMOP_B  = 3'b000;
  localparam logic [2:0] MEMOP_H  = 3'b001;
  localparam logic [2:0] MEMOP_W  = 3'b010;
  localparam logic [2:0] MEMOP_BU = 3'b100;
  localparam logic [2:0] MEMOP_HU = 3'b101;

  // Four bits cover the full 1..15 range of STARVE_MAX.
  localparam int STARVE_CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_WAIT = 2'b10
  } arb_state_t;

  typedef enum logic {
    OWN_IFU = 1'b0,
    OWN_LSU = 1'b1
  } owner_t;

  // Map the LSU grant of an accepted arbitration to the owner that is latched.
  function automatic owner_t grant_owner(input logic grant_lsu);
    owner_t own;
    if (grant_lsu) begin
      own = OWN_LSU;
    end else begin
      own = OWN_IFU;
    end
    return own;
  endfunction

endpackage

// File: rtl/arb_prio_starve.sv
// -----------------------------------------------------------------------------
// arb_prio_starve
// Two-way fixed-priority pick (LSU over IFU) with a saturating starvation
// counter that hands one contested arbitration to the IFU after STARVE_MAX
// consecutive contested losses.
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   ifu_valid  IFU is requesting
//   lsu_valid  LSU is requesting
//   accept     arbiter is able to take a request this cycle (FSM idle)
//   grant_ifu  IFU wins this cycle (combinational)
//   grant_lsu  LSU wins this cycle (combinational)
// -----------------------------------------------------------------------------
module arb_prio_starve
  import npc_mem_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic ifu_valid,
  input  logic lsu_valid,
  input  logic accept,
  output logic grant_ifu,
  output logic grant_lsu
);

  localparam logic [STARVE_CNT_W-1:0] STARVE_LIM = STARVE_CNT_W'(STARVE_MAX);

  logic [STARVE_CNT_W-1:0] starve_cnt_r;
  logic                    contested_s;
  logic                    ifu_turn_s;

  // Priority pick: LSU wins unless the IFU has lost STARVE_MAX contests in a row.
  always_comb begin
    contested_s = ifu_valid & lsu_valid;
    ifu_turn_s  = (starve_cnt_r == STARVE_LIM);
    grant_ifu   = ifu_valid & (~lsu_valid | ifu_turn_s);
    grant_lsu   = lsu_valid & ~(ifu_valid & ifu_turn_s);
  end

  // Starvation counter: only contested LSU wins count; any IFU grant clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt_r <= {STARVE_CNT_W{1'b0}};
    end else if (accept && grant_ifu) begin
      starve_cnt_r <= {STARVE_CNT_W{1'b0}};
    end else if (accept && contested_s && grant_lsu && (starve_cnt_r != STARVE_LIM)) begin
      starve_cnt_r <= starve_cnt_r + {{(STARVE_CNT_W-1){1'b0}}, 1'b1};
    end else begin
      starve_cnt_r <= starve_cnt_r;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
// Shares the single data-memory port between the IFU and the LSU. One request
// is latched in IDLE, presented to memory in REQ until accepted, and the
// response (WAIT, or same cycle as acceptance) is routed back to its owner.
// Only one transaction is ever outstanding.
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   ifu_req_valid/ready, ifu_addr  IFU fetch request (always a word load)
//   ifu_resp_valid, ifu_rdata      IFU response pulse and data
//   lsu_req_valid/ready, lsu_addr, lsu_wen, lsu_memop, lsu_wdata
//                                  LSU load/store request
//   lsu_resp_valid, lsu_rdata      LSU completion pulse, load data (0 on store)
//   mem_req_valid/ready, mem_addr, mem_wen, mem_memop, mem_wdata
//                                  latched request towards memory
//   mem_resp_valid, mem_rdata      memory response
// -----------------------------------------------------------------------------
module mem_port_arbiter
  import npc_mem_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ifu_req_valid,
  output logic              ifu_req_ready,
  input  logic [ADDR_W-1:0] ifu_addr,
  output logic              ifu_resp_valid,
  output logic [DATA_W-1:0] ifu_rdata,
  input  logic              lsu_req_valid,
  output logic              lsu_req_ready,
  input  logic [ADDR_W-1:0] lsu_addr,
  input  logic              lsu_wen,
  input  logic [2:0]        lsu_memop,
  input  logic [DATA_W-1:0] lsu_wdata,
  output logic              lsu_resp_valid,
  output logic [DATA_W-1:0] lsu_rdata,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wen,
  output logic [2:0]        mem_memop,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_resp_valid,
  input  logic [DATA_W-1:0] mem_rdata
);

  arb_state_t        state_r;
  arb_state_t        state_nx_s;
  owner_t            owner_r;
  logic [ADDR_W-1:0] addr_r;
  logic              wen_r;
  logic [2:0]        memop_r;
  logic [DATA_W-1:0] wdata_r;

  logic grant_ifu_s;
  logic grant_lsu_s;
  logic accept_s;
  logic load_s;
  logic done_s;

  assign accept_s = (state_r == ST_IDLE);

  arb_prio_starve #(
    .STARVE_MAX (STARVE_MAX)
  ) u_prio (
    .clk       (clk),
    .rst       (rst),
    .ifu_valid (ifu_req_valid),
    .lsu_valid (lsu_req_valid),
    .accept    (accept_s),
    .grant_ifu (grant_ifu_s),
    .grant_lsu (grant_lsu_s)
  );

  // Next-state and handshake decode; readies only exist in IDLE.
  always_comb begin
    state_nx_s    = state_r;
    ifu_req_ready = 1'b0;
    lsu_req_ready = 1'b0;
    mem_req_valid = 1'b0;
    load_s        = 1'b0;
    done_s        = 1'b0;
    case (state_r)
      ST_IDLE: begin
        ifu_req_ready = grant_ifu_s;
        lsu_req_ready = grant_lsu_s;
        if (grant_ifu_s || grant_lsu_s) begin
          load_s     = 1'b1;
          state_nx_s = ST_REQ;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_REQ: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready && mem_resp_valid) begin
          // memory accepted and answered in one cycle
          done_s     = 1'b1;
          state_nx_s = ST_IDLE;
        end else if (mem_req_ready) begin
          state_nx_s = ST_WAIT;
        end else begin
          state_nx_s = ST_REQ;
        end
      end
      ST_WAIT: begin
        if (mem_resp_valid) begin
          done_s     = 1'b1;
          state_nx_s = ST_IDLE;
        end else begin
          state_nx_s = ST_WAIT;
        end
      end
      default: begin
        state_nx_s = ST_IDLE;
      end
    endcase
  end

  // Response routing; data outputs are zero outside the completion cycle.
  always_comb begin
    ifu_resp_valid = 1'b0;
    lsu_resp_valid = 1'b0;
    ifu_rdata      = {DATA_W{1'b0}};
    lsu_rdata      = {DATA_W{1'b0}};
    if (done_s && (owner_r == OWN_IFU)) begin
      ifu_resp_valid = 1'b1;
      ifu_rdata      = mem_rdata;
    end else if (done_s && (owner_r == OWN_LSU)) begin
      lsu_resp_valid = 1'b1;
      if (wen_r) begin
        // stores complete without data
        lsu_rdata = {DATA_W{1'b0}};
      end else begin
        lsu_rdata = mem_rdata;
      end
    end else begin
      ifu_resp_valid = 1'b0;
      lsu_resp_valid = 1'b0;
    end
  end

  assign mem_addr  = addr_r;
  assign mem_wen   = wen_r;
  assign mem_memop = memop_r;
  assign mem_wdata = wdata_r;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Request latches, loaded on the accepting edge; IFU fetches are word loads.
  always_ff @(posedge clk) begin
    if (rst) begin
      owner_r <= OWN_LSU;
      addr_r  <= {ADDR_W{1'b0}};
      wen_r   <= 1'b0;
      memop_r <= 3'b000;
      wdata_r <= {DATA_W{1'b0}};
    end else if (load_s && grant_lsu_s) begin
      owner_r <= grant_owner(grant_lsu_s);
      addr_r  <= lsu_addr;
      wen_r   <= lsu_wen;
      memop_r <= lsu_memop;
      wdata_r <= lsu_wdata;
    end else if (load_s) begin
      owner_r <= grant_owner(grant_lsu_s);
      addr_r  <= ifu_addr;
      wen_r   <= 1'b0;
      memop_r <= MEMOP_W;
      wdata_r <= {DATA_W{1'b0}};
    end else begin
      owner_r <= owner_r;
      addr_r  <= addr_r;
      wen_r   <= wen_r;
      memop_r <= memop_r;
      wdata_r <= wdata_r;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
// Scoreboard bench: each accepted request pushes the response its owner should
// see; a negedge monitor pops and compares whenever a resp_valid appears.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        ifu_req_valid, ifu_req_ready, ifu_resp_valid;
  logic [31:0] ifu_addr, ifu_rdata;
  logic        lsu_req_valid, lsu_req_ready, lsu_wen, lsu_resp_valid;
  logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
  logic [2:0]  lsu_memop;
  logic        mem_req_valid, mem_req_ready, mem_wen, mem_resp_valid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [2:0]  mem_memop;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    bit          lsu;
    logic [31:0] data;
  } exp_t;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
    .ifu_resp_valid(ifu_resp_valid), .ifu_rdata(ifu_rdata),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
    .lsu_wen(lsu_wen), .lsu_memop(lsu_memop), .lsu_wdata(lsu_wdata),
    .lsu_resp_valid(lsu_resp_valid), .lsu_rdata(lsu_rdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
    .mem_wen(mem_wen), .mem_memop(mem_memop), .mem_wdata(mem_wdata),
    .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Response monitor / scoreboard consumer.
  always @(negedge clk) begin
    if (ifu_resp_valid || lsu_resp_valid) begin
      chk("resp_onehot", {63'd0, ifu_resp_valid & lsu_resp_valid}, 64'd0);
      if (sb_q.size() == 0) begin
        chk("unexpected_resp", {62'd0, ifu_resp_valid, lsu_resp_valid}, 64'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("resp_owner_lsu", {63'd0, lsu_resp_valid}, {63'd0, e.lsu});
        chk("resp_data", {32'd0, (e.lsu ? lsu_rdata : ifu_rdata)}, {32'd0, e.data});
      end
    end
  end

  task automatic idle_inputs();
    ifu_req_valid = 1'b0; ifu_addr = 32'd0;
    lsu_req_valid = 1'b0; lsu_addr = 32'd0; lsu_wen = 1'b0;
    lsu_memop = 3'b000; lsu_wdata = 32'd0;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_rdata = 32'd0;
  endtask

  task automatic chk_mem(input string tag, input logic [31:0] a, input bit w,
                         input logic [2:0] op, input logic [31:0] wd);
    chk({tag, "_valid"}, {63'd0, mem_req_valid}, 64'd1);
    chk({tag, "_addr"},  {32'd0, mem_addr}, {32'd0, a});
    chk({tag, "_wen"},   {63'd0, mem_wen}, {63'd0, w});
    chk({tag, "_memop"}, {61'd0, mem_memop}, {61'd0, op});
    chk({tag, "_wdata"}, {32'd0, mem_wdata}, {32'd0, wd});
  endtask

  // One single-master transaction. rdly: REQ stall cycles before ready.
  // rsp_dly: cycles from acceptance to response (0 = same cycle as ready).
  task automatic run_txn(input bit lsu, input logic [31:0] a, input bit w,
                         input logic [2:0] op, input logic [31:0] wd,
                         input int rdly, input int rsp_dly, input logic [31:0] rd);
    logic [31:0] exp_wd;
    logic [2:0]  exp_op;
    exp_wd = lsu ? wd : 32'd0;
    exp_op = lsu ? op : 3'b010;
    if (lsu) begin
      lsu_req_valid = 1'b1; lsu_addr = a; lsu_wen = w; lsu_memop = op; lsu_wdata = wd;
    end else begin
      ifu_req_valid = 1'b1; ifu_addr = a;
    end
    @(negedge clk);
    chk("grant_ready", {62'd0, ifu_req_ready, lsu_req_ready}, lsu ? 64'd1 : 64'd2);
    chk("idle_no_memreq", {63'd0, mem_req_valid}, 64'd0);
    sb_q.push_back('{lsu: lsu, data: (lsu && w) ? 32'd0 : rd});
    step();
    ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
    for (int i = 0; i < rdly; i++) begin
      @(negedge clk);
      chk_mem("stall", a, lsu ? w : 1'b0, exp_op, exp_wd);
      chk("stall_noresp", {62'd0, ifu_resp_valid, lsu_resp_valid}, 64'd0);
      step();
    end
    mem_req_ready = 1'b1;
    if (rsp_dly == 0) begin
      mem_resp_valid = 1'b1; mem_rdata = rd;
    end
    @(negedge clk);
    chk_mem("req", a, lsu ? w : 1'b0, exp_op, exp_wd);
    step();
    mem_req_ready = 1'b0;
    if (rsp_dly > 0) begin
      for (int i = 1; i < rsp_dly; i++) begin
        @(negedge clk);
        chk("wait_nomemreq", {63'd0, mem_req_valid}, 64'd0);
        chk("wait_noresp", {62'd0, ifu_resp_valid, lsu_resp_valid}, 64'd0);
        step();
      end
      mem_resp_valid = 1'b1; mem_rdata = rd;
      @(negedge clk);
      step();
    end
    mem_resp_valid = 1'b0; mem_rdata = 32'd0;
  endtask

  // Contested grant order with STARVE_MAX = 4 from a cleared counter (1 = IFU).
  localparam int N_ARB = 14;
  bit arb_exp_ifu [N_ARB] = '{0,0,0,0,1, 0,0,0,0,1, 0,0,0,0};

  initial begin
    idle_inputs();
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", {62'd0, ifu_req_ready, lsu_req_ready}, 64'd0);
    chk("rst_memreq", {63'd0, mem_req_valid}, 64'd0);
    chk("rst_mem_addr", {32'd0, mem_addr}, 64'd0);
    chk("rst_mem_wen_op", {60'd0, mem_wen, mem_memop}, 64'd0);
    chk("rst_resp", {62'd0, ifu_resp_valid, lsu_resp_valid}, 64'd0);
    step();

    // IFU fetch, ready at once, response two cycles after the request cycle.
    run_txn(1'b0, 32'h8000_0000, 1'b0, 3'b000, 32'd0, 0, 2, 32'h0000_0413);
    // LSU sb with three stall cycles.
    run_txn(1'b1, 32'h8000_1003, 1'b1, 3'b000, 32'h0000_00AB, 3, 1, 32'h1234_5678);
    // LSU lw completing in the first REQ cycle, then an immediate follow-up.
    run_txn(1'b1, 32'h8000_2000, 1'b0, 3'b010, 32'd0, 0, 0, 32'hDEAD_BEEF);
    run_txn(1'b1, 32'h8000_2004, 1'b0, 3'b101, 32'd0, 1, 0, 32'h0000_BEEF);

    // Contested arbitration (counter is 0 after the IFU fetch above).
    for (int k = 0; k < N_ARB; k++) begin
      ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0100 + 32'(k * 4);
      lsu_req_valid = 1'b1; lsu_addr = 32'h8000_3000 + 32'(k * 4);
      lsu_wen = 1'b0; lsu_memop = 3'b010; lsu_wdata = 32'd0;
      @(negedge clk);
      chk("arb_grant", {62'd0, ifu_req_ready, lsu_req_ready},
          arb_exp_ifu[k] ? 64'd2 : 64'd1);
      sb_q.push_back('{lsu: !arb_exp_ifu[k], data: 32'hA000_0000 + 32'(k)});
      step();
      mem_req_ready = 1'b1; mem_resp_valid = 1'b1; mem_rdata = 32'hA000_0000 + 32'(k);
      @(negedge clk);
      chk("arb_busy_noready", {62'd0, ifu_req_ready, lsu_req_ready}, 64'd0);
      chk("arb_mem_addr", {32'd0, mem_addr},
          {32'd0, arb_exp_ifu[k] ? ifu_addr : lsu_addr});
      step();
      mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_rdata = 32'd0;
    end
    ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;

    // Counter now saturated; reset during an LSU WAIT must clear it.
    lsu_req_valid = 1'b1; lsu_addr = 32'h8000_4000; lsu_wen = 1'b0; lsu_memop = 3'b010;
    @(negedge clk);
    chk("rstw_grant", {63'd0, lsu_req_ready}, 64'd1);
    step();
    lsu_req_valid = 1'b0; mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0; mem_resp_valid = 1'b1; mem_rdata = 32'h5555_AAAA;
    @(negedge clk);
    chk("rstw_resp_dropped", {62'd0, ifu_resp_valid, lsu_resp_valid}, 64'd0);
    chk("rstw_idle", {63'd0, mem_req_valid}, 64'd0);
    step();
    mem_resp_valid = 1'b0; mem_rdata = 32'd0;
    // Contested: a cleared counter means LSU wins.
    ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0200;
    lsu_req_valid = 1'b1; lsu_addr = 32'h8000_5000;
    @(negedge clk);
    chk("rstw_cnt_cleared", {62'd0, ifu_req_ready, lsu_req_ready}, 64'd1);
    sb_q.push_back('{lsu: 1'b1, data: 32'h0BAD_F00D});
    step();
    ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
    mem_req_ready = 1'b1; mem_resp_valid = 1'b1; mem_rdata = 32'h0BAD_F00D;
    step();
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_rdata = 32'd0;
    run_txn(1'b0, 32'h8000_0300, 1'b0, 3'b000, 32'd0, 1, 1, 32'h0010_0093);

    // Stray memory response in IDLE.
    mem_resp_valid = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    chk("idle_resp_ignored", {62'd0, ifu_resp_valid, lsu_resp_valid}, 64'd0);
    step();
    mem_resp_valid = 1'b0; mem_rdata = 32'd0;
    @(negedge clk);
    chk("idle_no_state_change", {63'd0, mem_req_valid}, 64'd0);
    step();
    run_txn(1'b0, 32'h8000_0400, 1'b0, 3'b000, 32'd0, 0, 1, 32'h0000_0013);

    repeat (2) step();
    chk("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
